// File: rtl/rto_dac_cmd_decoder.sv
// Decodes timed RTO instructions into DDS frequency/phase/amplitude registers.
// Includes a prescaled linear amplitude-ramp engine with clamped steps.
module rto_dac_cmd_decoder #(
  parameter int unsigned RAMP_PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         counter_matched,
  input  logic [127:0] rto_out,
  output logic [47:0]  freq_word,
  output logic [15:0]  phase_offset,
  output logic [13:0]  amplitude,
  output logic         phase_reset,
  output logic         param_update,
  output logic         ramp_busy,
  output logic         cmd_error,
  output logic [63:0]  cmd_error_data
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  localparam logic [15:0] TC = 16'(RAMP_PRESCALE - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [13:0] r_target;
  logic [13:0] r_step;

  logic [63:0] w_payload;
  logic [3:0]  w_op;
  logic [13:0] w_cmd_tgt;
  logic [13:0] w_cmd_step;
  logic        w_ramp_now;
  logic        w_tc;
  logic        w_step_fire;
  logic [14:0] w_sum;
  logic [14:0] w_diff;
  logic [13:0] w_up_amp;
  logic [13:0] w_dn_amp;
  logic [13:0] w_step_amp;
  logic [47:0] w_freq_n;
  logic [15:0] w_phase_n;
  logic [13:0] w_amp_n;
  logic        w_param_chg;
  logic        w_unused;

  assign w_unused   = ^rto_out[127:64];
  assign w_payload  = rto_out[63:0];
  assign w_op       = w_payload[63:60];
  assign w_cmd_tgt  = w_payload[13:0];
  assign w_cmd_step = w_payload[29:16];
  // A ramp that would not move settles immediately on the capture edge.
  assign w_ramp_now = (w_cmd_step == '0) || (w_cmd_tgt == amplitude);

  assign w_tc        = (r_cnt == TC);
  assign w_step_fire = (r_state != IDLE) && !flush && w_tc;

  // 15-bit arithmetic: bit 14 of w_diff flags an underflow below zero.
  assign w_sum    = {1'b0, amplitude} + {1'b0, r_step};
  assign w_diff   = {1'b0, amplitude} - {1'b0, r_step};
  assign w_up_amp = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[13:0];
  assign w_dn_amp = (w_diff[14] || (w_diff[13:0] <= r_target)) ? r_target : w_diff[13:0];
  assign w_step_amp = (r_state == RAMP_UP) ? w_up_amp : w_dn_amp;

  always_comb begin
    w_freq_n  = freq_word;
    w_phase_n = phase_offset;
    w_amp_n   = w_step_fire ? w_step_amp : amplitude;
    if (counter_matched) begin
      case (w_op)
        4'h1:    w_freq_n  = w_payload[47:0];
        4'h2:    w_phase_n = w_payload[15:0];
        4'h3:    w_amp_n   = w_cmd_tgt;
        4'h4:    w_amp_n   = w_ramp_now ? w_cmd_tgt : amplitude;
        default: ;
      endcase
    end
    w_param_chg = (w_freq_n != freq_word) || (w_phase_n != phase_offset) ||
                  (w_amp_n != amplitude);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_target       <= '0;
      r_step         <= '0;
      freq_word      <= '0;
      phase_offset   <= '0;
      amplitude      <= '0;
      phase_reset    <= 1'b0;
      param_update   <= 1'b0;
      ramp_busy      <= 1'b0;
      cmd_error      <= 1'b0;
      cmd_error_data <= '0;
    end else begin
      freq_word    <= w_freq_n;
      phase_offset <= w_phase_n;
      amplitude    <= w_amp_n;
      param_update <= w_param_chg;
      phase_reset  <= counter_matched && (w_op == 4'h5);
      cmd_error    <= counter_matched && (w_op >= 4'h6);
      if (counter_matched && (w_op >= 4'h6)) cmd_error_data <= w_payload;

      // Amplitude commands take priority over flush and over an in-flight step.
      if (counter_matched && (w_op == 4'h3)) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        ramp_busy <= 1'b0;
      end else if (counter_matched && (w_op == 4'h4)) begin
        r_target <= w_cmd_tgt;
        r_step   <= w_cmd_step;
        r_cnt    <= '0;
        if (w_ramp_now) begin
          r_state   <= IDLE;
          ramp_busy <= 1'b0;
        end else begin
          r_state   <= (w_cmd_tgt > amplitude) ? RAMP_UP : RAMP_DOWN;
          ramp_busy <= 1'b1;
        end
      end else begin
        case (r_state)
          RAMP_UP, RAMP_DOWN: begin
            if (flush) begin
              r_state   <= IDLE;
              r_cnt     <= '0;
              ramp_busy <= 1'b0;
            end else if (w_tc) begin
              r_cnt <= '0;
              if (w_step_amp == r_target) begin
                r_state   <= IDLE;
                ramp_busy <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            ramp_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/rto_dac_cmd_decoder.md
Name: rto_dac_cmd_decoder

Overview:
- Sits directly downstream of the per-channel RTO core in each DAC controller.
- Captures the 128-bit timed instruction on the RTO core's counter_matched pulse and decodes the 64-bit payload into DDS parameter registers: frequency, phase, amplitude, and a phase-sync pulse.
- Includes a linear amplitude-ramp engine, so amplitude changes can be slewed rather than stepped.
- Outputs drive the DDS/DAC datapath directly.

Parameters:
- RAMP_PRESCALE, 1, clock cycles per ramp step (1..65535). Internal prescale counter is 16 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset. Clears all state.
- flush  in  1  synchronous abort of any ramp in progress. Amplitude holds its present value.
- counter_matched  in  1  one-cycle strobe from the RTO core: rto_out holds a new instruction.
- rto_out  in  128  [127:64] timestamp (ignored); [63:0] payload.
- freq_word  out  48  DDS frequency tuning word.
- phase_offset  out  16  DDS phase offset.
- amplitude  out  14  DDS amplitude (unsigned).
- phase_reset  out  1  one-cycle DDS phase-accumulator clear.
- param_update  out  1  one-cycle pulse whenever freq_word, phase_offset or amplitude changes value.
- ramp_busy  out  1  high while the ramp engine is active.
- cmd_error  out  1  one-cycle pulse on an illegal opcode.
- cmd_error_data  out  64  payload of the most recent illegal command.

Behaviour:
- Reset values: all outputs 0; state IDLE; prescale counter 0.
- Payload format: opcode = payload[63:60].
  - 0x1 SET_FREQ: freq_word <= payload[47:0].
  - 0x2 SET_PHASE: phase_offset <= payload[15:0].
  - 0x3 SET_AMP: amplitude <= payload[13:0]; any ramp is cancelled (state -> IDLE).
  - 0x4 RAMP_AMP: target <= payload[13:0], step <= payload[29:16] (14-bit), then start a ramp.
  - 0x5 SYNC: phase_reset = 1 for one cycle.
  - 0x0 NOP: no effect.
  - 0x6-0xF: illegal. cmd_error pulses; cmd_error_data <= payload; no other effect.
- Latency: register outputs, phase_reset, cmd_error and param_update all update on the edge following the cycle in which counter_matched = 1. Exactly one cycle of latency.
- Unused payload bits are ignored. No checking of reserved fields.
- Ramp state machine has three states: IDLE, RAMP_UP, RAMP_DOWN.
- On RAMP_AMP capture, amplitude is unchanged at the capture edge. The next state is chosen as follows:
  - step == 0, or target == amplitude: amplitude <= target at the capture edge; state stays IDLE. param_update pulses only if the value changed.
  - target > amplitude: RAMP_UP.
  - target < amplitude: RAMP_DOWN.
- While in RAMP_UP or RAMP_DOWN:
  - The prescale counter counts 0..RAMP_PRESCALE-1. It is cleared at capture.
  - On each terminal count, amplitude moves by step toward target.
  - Arithmetic is 15-bit with clamp: if the sum overshoots target (up) or the difference undershoots target or underflows 0 (down), amplitude <= target.
  - When amplitude reaches target, state -> IDLE at that same edge.
  - param_update pulses on every amplitude step.
- With RAMP_PRESCALE = 1, the first step lands two edges after the counter_matched cycle.
- ramp_busy = (state != IDLE), driven from a register.
- Simultaneous events:
  - A new RAMP_AMP during a ramp restarts the ramp from the current amplitude with the new target and step.
  - SET_FREQ, SET_PHASE and SYNC during a ramp apply without disturbing the ramp.
  - flush together with counter_matched: flush kills the current ramp first, then the command is decoded normally. A RAMP_AMP in that same cycle therefore starts a new ramp.
  - flush while IDLE has no effect.
- A param_update triggered by a command and one triggered by a ramp step in the same cycle merge into a single pulse.
- Reset asserted mid-ramp clears everything immediately (asynchronous). After release the block is IDLE with all outputs 0.
- counter_matched held high on consecutive cycles: each cycle is decoded as an independent command. Commands are never dropped.

Test Plan:
- Reset then SET_FREQ payload 0x1000_1234_5678_9ABC -> freq_word = 0x1234_5678_9ABC one cycle later; param_update pulses once; other outputs remain 0.
- SET_AMP 0x0100, then RAMP_AMP target 0x0110 step 0x0005, RAMP_PRESCALE = 1 -> amplitude sequence 0x0105, 0x010A, 0x010F, 0x0110 on successive cycles; ramp_busy deasserts at the 0x0110 edge; param_update pulses 4 times.
- RAMP_AMP target 0x0000 step 0x3FFF from amplitude 0x0010 -> single clamp step to 0x0000 with no wrap; RAMP_PRESCALE = 4 -> step occurs 4 cycles after entering RAMP_DOWN.
- Opcode 0x9 with payload 0x9000_0000_0000_00AA -> cmd_error pulses once; cmd_error_data = 0x9000_0000_0000_00AA; freq_word, phase_offset and amplitude unchanged; no param_update.
- During a ramp, issue SYNC then SET_PHASE 0xBEEF on back-to-back counter_matched cycles -> phase_reset pulses one cycle; phase_offset = 0xBEEF; ramp continues uninterrupted. Then assert flush -> ramp_busy = 0 and amplitude holds its value.
- Assert reset asynchronously (between clock edges) mid-ramp -> all outputs read 0 before the next clk edge; after release, a RAMP_AMP with step 0 and target 0x0055 sets amplitude = 0x0055 immediately, with ramp_busy remaining 0.
